// File: rtl/lcm_pkg.sv
// Shared types and constants for the sequential gcd/lcm engine.
package lcm_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int K_W = $clog2(WIDTH_DEF + 1);

    typedef enum logic [2:0] {
        IDLE,
        GCD,
        DIV,
        MUL,
        DONE
    } state_t;

endpackage

// File: rtl/gcd_core.sv
// Sequential binary (Stein) gcd iterator, one step per clock.
module gcd_core
    import lcm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] g
);

    localparam int KW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [KW-1:0]    k;
    logic             run;

    // done and g are valid in the same cycle as the terminating x==y step
    assign busy = run;
    assign done = run && (x == y);
    assign g    = x << k;

    always_ff @(posedge clk) begin
        if (rst) begin
            run <= 1'b0;
            x   <= '0;
            y   <= '0;
            k   <= '0;
        end else if (start && !run) begin
            run <= 1'b1;
            x   <= x0;
            y   <= y0;
            k   <= '0;
        end else if (run) begin
            if (x == y) begin
                run <= 1'b0;
            end else if (!x[0] && !y[0]) begin
                x <= x >> 1;
                y <= y >> 1;
                k <= k + KW'(1);
            end else if (!x[0]) begin
                x <= x >> 1;
            end else if (!y[0]) begin
                y <= y >> 1;
            end else if (x > y) begin
                x <= x - y;
            end else begin
                y <= y - x;
            end
        end
    end

endmodule

// File: rtl/lcm_seq.sv
// Handshaked lcm engine: Stein gcd, restoring divide, shift-add multiply.
module lcm_seq
    import lcm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   gcd_result,
    output logic [2*WIDTH-1:0] lcm_result
);

    localparam int CW = $clog2(WIDTH);

    state_t state;
    state_t nxt;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   gr;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   qa;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic               zero;
    logic               core_start;
    logic               core_busy;
    logic               core_done;
    logic [WIDTH-1:0]   core_g;
    logic               last;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic               fits;
    logic [2*WIDTH-1:0] acc_nxt;

    assign zero       = (a == '0) || (b == '0);
    assign core_start = (state == IDLE) && in_valid && !zero && !core_busy;
    assign last       = (cnt == CW'(WIDTH - 1));
    assign trial      = {rem, qa[WIDTH-1]};
    assign diff       = trial - {1'b0, gr};
    assign fits       = (trial >= {1'b0, gr});
    assign acc_nxt    = qa[0] ? acc + mcand : acc;

    gcd_core #(.WIDTH(WIDTH)) u_gcd (
        .clk   (clk),
        .rst   (rst),
        .start (core_start),
        .x0    (a),
        .y0    (b),
        .busy  (core_busy),
        .done  (core_done),
        .g     (core_g)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (in_valid) nxt = zero ? DONE : GCD;
            GCD:  if (core_done) nxt = DIV;
            DIV:  if (last) nxt = MUL;
            MUL:  if (last) nxt = DONE;
            DONE: if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            gr         <= '0;
            rem        <= '0;
            qa         <= '0;
            mcand      <= '0;
            acc        <= '0;
            cnt        <= '0;
            gcd_result <= '0;
            lcm_result <= '0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    a_q   <= a;
                    mcand <= {{WIDTH{1'b0}}, b};
                    if (zero) begin
                        gcd_result <= a | b;
                        lcm_result <= '0;
                    end
                end
                GCD: if (core_done) begin
                    gr  <= core_g;
                    qa  <= a_q;
                    rem <= '0;
                    acc <= '0;
                    cnt <= '0;
                end
                // qa doubles as dividend shifter and, afterwards, multiplier
                DIV: begin
                    rem <= fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                    qa  <= {qa[WIDTH-2:0], fits};
                    cnt <= last ? '0 : cnt + CW'(1);
                end
                MUL: begin
                    acc   <= acc_nxt;
                    mcand <= mcand << 1;
                    qa    <= qa >> 1;
                    cnt   <= last ? '0 : cnt + CW'(1);
                    if (last) begin
                        gcd_result <= gr;
                        lcm_result <= acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcm_seq.sv
// Directed self-checking bench for lcm_seq.
module tb_lcm_seq;

    localparam int W = 32;
    localparam int LIMIT = 400;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   gcd_result;
    logic [2*W-1:0] lcm_result;

    int tests = 0;
    int fails = 0;

    lcm_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .gcd_result (gcd_result),
        .lcm_result (lcm_result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one pair, scramble a/b while busy, wait for out_valid.
    // cyc = clock edges after the acceptance edge until out_valid is seen.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int cyc, output int busy_bad);
        int guard;
        cyc = 0;
        busy_bad = 0;
        guard = 0;
        while (!in_ready && guard < LIMIT) begin
            tick();
            guard++;
        end
        a = av;
        b = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        while (!out_valid && cyc < LIMIT) begin
            if (in_ready) busy_bad++;
            a = $urandom;
            b = $urandom;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        tick();
        tick();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0",
                     in_ready, out_valid);
            fails++;
        end
        tests++;
        if (gcd_result !== '0 || lcm_result !== '0) begin
            $display("FAIL reset_data: gcd=%h lcm=%h want 0/0",
                     gcd_result, lcm_result);
            fails++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int cyc, bb;
        out_ready = 1'b1;
        run_op(32'd12, 32'd18, cyc, bb);
        tests++;
        if (gcd_result !== 32'd6 || lcm_result !== 64'd36) begin
            $display("FAIL basic_12_18: gcd=%0d lcm=%0d want 6/36",
                     gcd_result, lcm_result);
            fails++;
        end
        // Stein on 12,18 takes G=5 steps; then 32 divide + 32 multiply
        tests++;
        if (cyc != 5 + 2 * W) begin
            $display("FAIL basic_latency: got %0d want %0d", cyc, 5 + 2 * W);
            fails++;
        end
        tests++;
        if (bb != 0) begin
            $display("FAIL basic_busy_ready: in_ready high %0d busy cycles want 0", bb);
            fails++;
        end
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL basic_one_cycle: out_valid=%b in_ready=%b want 0/1",
                     out_valid, in_ready);
            fails++;
        end
    endtask

    task automatic test_zero();
        int cyc, bb;
        out_ready = 1'b1;
        run_op(32'd0, 32'd7, cyc, bb);
        tests++;
        if (gcd_result !== 32'd7 || lcm_result !== 64'd0) begin
            $display("FAIL zero_0_7: gcd=%0d lcm=%0d want 7/0",
                     gcd_result, lcm_result);
            fails++;
        end
        tests++;
        if (cyc != 0) begin
            $display("FAIL zero_latency: got %0d want 0", cyc);
            fails++;
        end
        tick();
        run_op(32'd0, 32'd0, cyc, bb);
        tests++;
        if (gcd_result !== 32'd0 || lcm_result !== 64'd0 || cyc != 0) begin
            $display("FAIL zero_0_0: gcd=%0d lcm=%0d cyc=%0d want 0/0/0",
                     gcd_result, lcm_result, cyc);
            fails++;
        end
        tick();
    endtask

    task automatic test_allones();
        int cyc, bb;
        out_ready = 1'b1;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bb);
        tests++;
        if (gcd_result !== 32'hFFFF_FFFF || lcm_result !== 64'h0000_0000_FFFF_FFFF) begin
            $display("FAIL allones: gcd=%h lcm=%h want ffffffff/00000000ffffffff",
                     gcd_result, lcm_result);
            fails++;
        end
        tick();
    endtask

    task automatic test_coprime();
        int cyc, bb;
        out_ready = 1'b1;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, cyc, bb);
        tests++;
        if (gcd_result !== 32'd1 || lcm_result !== 64'hFFFF_FFFD_0000_0002) begin
            $display("FAIL coprime: gcd=%h lcm=%h want 1/fffffffd00000002",
                     gcd_result, lcm_result);
            fails++;
        end
        tests++;
        if (cyc + 1 > 1 + 4 * W + 2 * W) begin
            $display("FAIL coprime_latency: got %0d want <= %0d",
                     cyc + 1, 1 + 4 * W + 2 * W);
            fails++;
        end
        tick();
    endtask

    task automatic test_hold();
        int cyc, bb, bad;
        out_ready = 1'b0;
        run_op(32'd48, 32'd64, cyc, bb);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                gcd_result !== 32'd16 || lcm_result !== 64'd192)
                bad++;
            tick();
        end
        tests++;
        if (bad != 0) begin
            $display("FAIL hold_stable: %0d bad cycles want 0 (gcd=%0d lcm=%0d)",
                     bad, gcd_result, lcm_result);
            fails++;
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL hold_release: out_valid=%b in_ready=%b want 0/1",
                     out_valid, in_ready);
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bb;
        out_ready = 1'b1;
        a = 32'd12;
        b = 32'd18;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        // 5 Stein steps then 10 cycles into the divide
        for (int i = 0; i < 15; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            gcd_result !== '0 || lcm_result !== '0) begin
            $display("FAIL reset_mid: ov=%b ir=%b gcd=%h lcm=%h want 0/1/0/0",
                     out_valid, in_ready, gcd_result, lcm_result);
            fails++;
        end
        run_op(32'd7, 32'd5, cyc, bb);
        tests++;
        if (gcd_result !== 32'd1 || lcm_result !== 64'd35) begin
            $display("FAIL after_reset_7_5: gcd=%0d lcm=%0d want 1/35",
                     gcd_result, lcm_result);
            fails++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, bb;
        out_ready = 1'b1;
        run_op(32'd21, 32'd6, cyc, bb);
        tests++;
        if (gcd_result !== 32'd3 || lcm_result !== 64'd42 || cyc >= LIMIT) begin
            $display("FAIL b2b_21_6: gcd=%0d lcm=%0d cyc=%0d want 3/42",
                     gcd_result, lcm_result, cyc);
            fails++;
        end
        tick();
        run_op(32'd100000, 32'd75, cyc, bb);
        tests++;
        if (gcd_result !== 32'd25 || lcm_result !== 64'd300000 || cyc >= LIMIT) begin
            $display("FAIL b2b_100000_75: gcd=%0d lcm=%0d cyc=%0d want 25/300000",
                     gcd_result, lcm_result, cyc);
            fails++;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_allones();
        test_coprime();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
